// File: rtl/spi_frame_scheduler_if.sv
// Bus between the SPI frame scheduler and its surroundings: slave-side frame buffers,
// channel feedback in, committed setpoints/status out, plus the FSM state for observation.
interface spi_frame_scheduler_if #(
  parameter int CHANNELS = 2,
  parameter int CH_WIDTH = 32
);
  localparam int DATA_W      = CHANNELS * CH_WIDTH;
  localparam int BUFFER_SIZE = 48 + DATA_W;

  logic                   ssel;
  logic [BUFFER_SIZE-1:0] rx_frame;
  logic                   pkg_timeout;
  logic [DATA_W-1:0]      fb_data;
  logic [BUFFER_SIZE-1:0] tx_frame;
  logic [DATA_W-1:0]      sp_data;
  logic                   sp_update;
  logic [7:0]             out_flags;
  logic                   enable;
  logic [7:0]             frame_seq;
  logic [7:0]             err_count;
  logic [1:0]             state;

  modport slave (
    input  ssel, rx_frame, pkg_timeout, fb_data,
    output tx_frame, sp_data, sp_update, out_flags, enable, frame_seq, err_count, state
  );

  modport master (
    output ssel, rx_frame, pkg_timeout, fb_data,
    input  tx_frame, sp_data, sp_update, out_flags, enable, frame_seq, err_count, state
  );
endinterface

// File: rtl/spi_frame_scheduler.sv
// Frame-level controller for the SPI slave: snapshots tx at frame start, validates and commits
// the received frame at frame end, and drops to a safe fault state on link loss.
module spi_frame_scheduler #(
  parameter logic [31:0] MSGID    = 32'h74697277,
  parameter int          CHANNELS = 2,
  parameter int          CH_WIDTH = 32,
  parameter int          XFER_MAX = 480000
) (
  input logic                  clk,
  input logic                  reset,
  spi_frame_scheduler_if.slave bus
);
  localparam int DATA_W      = CHANNELS * CH_WIDTH;
  localparam int BUFFER_SIZE = 48 + DATA_W;
  localparam int CNT_W       = $clog2(XFER_MAX + 1);

  // state encoding is exposed on bus.state: IDLE=0, XFER=1, COMMIT=2, FAULT=3
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    XFER   = 2'd1,
    COMMIT = 2'd2,
    FAULT  = 2'd3
  } state_t;

  state_t                 state;
  logic [2:0]             ssel_sr;
  logic                   pkg_timeout_q;
  logic                   fault;
  logic [CNT_W-1:0]       xfer_cnt;
  logic [BUFFER_SIZE-1:0] tx_frame;
  logic [DATA_W-1:0]      sp_data;
  logic                   sp_update;
  logic [7:0]             out_flags;
  logic                   enable;
  logic [7:0]             frame_seq;
  logic [7:0]             err_count;

  logic                   start;
  logic                   stop;
  logic                   timeout_rise;
  logic [31:0]            rx_header;
  logic [7:0]             rx_seq;
  logic [7:0]             rx_flags;
  logic [DATA_W-1:0]      rx_data;

  assign start        = (ssel_sr[2:1] == 2'b10);
  assign stop         = (ssel_sr[2:1] == 2'b01);
  assign timeout_rise = bus.pkg_timeout & ~pkg_timeout_q;

  assign rx_header = bus.rx_frame[BUFFER_SIZE-1 -: 32];
  assign rx_seq    = bus.rx_frame[BUFFER_SIZE-33 -: 8];
  assign rx_flags  = bus.rx_frame[BUFFER_SIZE-41 -: 8];
  assign rx_data   = bus.rx_frame[DATA_W-1:0];

  assign bus.tx_frame  = tx_frame;
  assign bus.sp_data   = sp_data;
  assign bus.sp_update = sp_update;
  assign bus.out_flags = out_flags;
  assign bus.enable    = enable;
  assign bus.frame_seq = frame_seq;
  assign bus.err_count = err_count;
  assign bus.state     = state;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      // zero preload: a frame already in progress at reset release never looks like a start
      ssel_sr       <= 3'b000;
      pkg_timeout_q <= 1'b0;
      fault         <= 1'b1;
      xfer_cnt      <= '0;
      tx_frame      <= {MSGID, 8'h00, 8'h80, {DATA_W{1'b0}}};
      sp_data       <= '0;
      sp_update     <= 1'b0;
      out_flags     <= 8'h00;
      enable        <= 1'b0;
      frame_seq     <= 8'h00;
      err_count     <= 8'h00;
    end else begin
      ssel_sr       <= {ssel_sr[1:0], bus.ssel};
      pkg_timeout_q <= bus.pkg_timeout;
      sp_update     <= 1'b0;
      enable        <= ~fault;
      if (timeout_rise) begin
        state     <= FAULT;
        fault     <= 1'b1;
        enable    <= 1'b0;
        out_flags <= 8'h00;
        sp_update <= 1'b1;
      end else begin
        case (state)
          IDLE, FAULT: begin
            if (start) begin
              tx_frame <= {MSGID, frame_seq,
                           {fault, bus.pkg_timeout, 1'b0, err_count[4:0]}, bus.fb_data};
              xfer_cnt <= '0;
              state    <= XFER;
            end
          end
          XFER: begin
            xfer_cnt <= xfer_cnt + 1'b1;
            if (stop) begin
              state <= COMMIT;
            end else if (xfer_cnt == CNT_W'(XFER_MAX - 1)) begin
              err_count <= sat_inc(err_count);
              state     <= fault ? FAULT : IDLE;
            end
          end
          COMMIT: begin
            // after a fault the first good header is accepted regardless of SEQ
            if (rx_header != MSGID || (rx_seq == frame_seq && !fault)) begin
              err_count <= sat_inc(err_count);
              state     <= fault ? FAULT : IDLE;
            end else begin
              sp_data   <= rx_data;
              out_flags <= rx_flags;
              frame_seq <= rx_seq;
              sp_update <= 1'b1;
              fault     <= bus.pkg_timeout;
              state     <= bus.pkg_timeout ? FAULT : IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_frame_scheduler.sv
// Directed bench for spi_frame_scheduler: expected setpoint updates are queued as frames are
// driven and matched by a monitor on sp_update; status outputs are checked at fixed points.
module tb_spi_frame_scheduler;
  localparam logic [31:0] MSGID = 32'h74697277;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  logic [71:0] exp_q[$];

  spi_frame_scheduler_if #(.CHANNELS(2), .CH_WIDTH(32)) dut_if ();

  spi_frame_scheduler #(
    .MSGID(MSGID), .CHANNELS(2), .CH_WIDTH(32), .XFER_MAX(100)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(dut_if)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every sp_update pulse must match the oldest queued {sp_data, out_flags}
  always @(negedge clk) begin
    if (dut_if.sp_update === 1'b1) begin
      if (exp_q.size() != 0) begin
        check("update_data", 128'({dut_if.sp_data, dut_if.out_flags}), 128'(exp_q.pop_front()));
      end else begin
        check("spurious_update", 128'(dut_if.sp_update), 128'(0));
      end
    end
  end

  // driver tasks
  task automatic run_frame(input logic [31:0] hdr, input logic [7:0] seq, input logic [7:0] flags,
                           input logic [63:0] data, input int low_cycles);
    @(negedge clk);
    dut_if.ssel     = 1'b0;
    dut_if.rx_frame = {hdr, seq, flags, data};
    repeat (low_cycles) @(negedge clk);
    dut_if.ssel = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_update(input string tag);
    int n = 0;
    while (dut_if.sp_update !== 1'b1 && n < 12) begin
      @(negedge clk);
      n++;
    end
    check(tag, 128'(dut_if.sp_update), 128'(1));
  endtask

  initial begin
    logic [63:0] d;
    dut_if.ssel        = 1'b1;
    dut_if.pkg_timeout = 1'b0;
    dut_if.fb_data     = '0;
    dut_if.rx_frame    = '0;

    // 1: reset values
    repeat (3) @(negedge clk);
    check("rst_enable", 128'(dut_if.enable), 128'(0));
    check("rst_tx", 128'(dut_if.tx_frame), 128'({MSGID, 8'h00, 8'h80, 64'h0}));
    check("rst_update", 128'(dut_if.sp_update), 128'(0));
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_state", 128'(dut_if.state), 128'(0));
    check("idle_err", 128'(dut_if.err_count), 128'(0));

    // 2: first frame, fb snapshot held across mid-frame change
    exp_q.push_back({64'h00000001_00000002, 8'h5A});
    dut_if.fb_data  = 64'hAAAA0001_BBBB0002;
    dut_if.rx_frame = {MSGID, 8'h01, 8'h5A, 64'h00000001_00000002};
    dut_if.ssel     = 1'b0;
    repeat (5) @(negedge clk);
    check("xfer_state", 128'(dut_if.state), 128'(1));
    dut_if.fb_data = 64'h12345678_9ABCDEF0;
    repeat (5) @(negedge clk);
    check("tx_snapshot", 128'(dut_if.tx_frame), 128'({MSGID, 8'h00, 8'h80, 64'hAAAA0001_BBBB0002}));
    dut_if.ssel = 1'b1;
    wait_update("first_update");
    check("enable_lag", 128'(dut_if.enable), 128'(0));
    @(negedge clk);
    check("enable_up", 128'(dut_if.enable), 128'(1));
    check("update_pulse", 128'(dut_if.sp_update), 128'(0));
    check("flags_5a", 128'(dut_if.out_flags), 128'(8'h5A));
    check("seq_01", 128'(dut_if.frame_seq), 128'(8'h01));
    repeat (4) @(negedge clk);

    // 3: stale SEQ, then bad header
    run_frame(MSGID, 8'h01, 8'h77, 64'hFFFF0000_FFFF0000, 6);
    check("stale_err", 128'(dut_if.err_count), 128'(1));
    check("stale_flags", 128'(dut_if.out_flags), 128'(8'h5A));
    run_frame(32'hDEADBEEF, 8'h02, 8'h66, 64'h11110000_22220000, 6);
    check("hdr_err", 128'(dut_if.err_count), 128'(2));
    check("hdr_seq", 128'(dut_if.frame_seq), 128'(8'h01));

    // 4: SSEL held low past XFER_MAX
    @(negedge clk);
    dut_if.ssel = 1'b0;
    repeat (95) @(negedge clk);
    check("long_xfer", 128'(dut_if.state), 128'(1));
    check("long_tx_hdr", 128'(dut_if.tx_frame[79:64]), 128'({8'h01, 8'h02}));
    repeat (15) @(negedge clk);
    check("abort_state", 128'(dut_if.state), 128'(0));
    check("abort_err", 128'(dut_if.err_count), 128'(3));
    dut_if.ssel = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_idle", 128'(dut_if.state), 128'(0));
    check("abort_enable", 128'(dut_if.enable), 128'(1));

    // 5: link timeout, bad frame under fault, recovery with same SEQ
    exp_q.push_back({64'h00000001_00000002, 8'h00});
    dut_if.pkg_timeout = 1'b1;
    wait_update("fault_update");
    check("fault_state", 128'(dut_if.state), 128'(3));
    check("fault_flags", 128'(dut_if.out_flags), 128'(0));
    check("fault_enable", 128'(dut_if.enable), 128'(0));
    @(negedge clk);
    dut_if.ssel     = 1'b0;
    dut_if.rx_frame = {32'hDEADBEEF, 8'h09, 8'h00, 64'h0};
    repeat (5) @(negedge clk);
    check("fault_status", 128'(dut_if.tx_frame[71:64]), 128'(8'hC3));
    dut_if.ssel = 1'b1;
    repeat (8) @(negedge clk);
    check("fault_err", 128'(dut_if.err_count), 128'(4));
    check("fault_hold", 128'(dut_if.state), 128'(3));
    dut_if.pkg_timeout = 1'b0;
    d = 64'hCAFE0001_F00D0002;
    exp_q.push_back({d, 8'h3C});
    @(negedge clk);
    dut_if.ssel     = 1'b0;
    dut_if.rx_frame = {MSGID, 8'h01, 8'h3C, d};
    repeat (5) @(negedge clk);
    check("recov_status", 128'(dut_if.tx_frame[71:64]), 128'(8'h84));
    dut_if.ssel = 1'b1;
    wait_update("recov_update");
    @(negedge clk);
    check("recov_enable", 128'(dut_if.enable), 128'(1));
    check("recov_state", 128'(dut_if.state), 128'(0));

    // 6: reset during a transfer
    dut_if.ssel     = 1'b0;
    dut_if.rx_frame = {MSGID, 8'h07, 8'h11, 64'h0};
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_tx", 128'(dut_if.tx_frame), 128'({MSGID, 8'h00, 8'h80, 64'h0}));
    check("mid_rst_out", 128'({dut_if.sp_data, dut_if.out_flags, dut_if.frame_seq, dut_if.err_count}),
          128'(0));
    check("mid_rst_en", 128'(dut_if.enable), 128'(0));
    repeat (4) @(negedge clk);
    check("mid_rst_idle", 128'(dut_if.state), 128'(0));
    dut_if.ssel = 1'b1;
    repeat (8) @(negedge clk);
    check("post_rst_noseq", 128'(dut_if.frame_seq), 128'(0));
    d = 64'h00000BAD_00000F00 + 64'($urandom_range(0, 255));
    exp_q.push_back({d, 8'h11});
    run_frame(MSGID, 8'h07, 8'h11, d, 8);
    check("post_rst_seq", 128'(dut_if.frame_seq), 128'(8'h07));
    check("post_rst_en", 128'(dut_if.enable), 128'(1));
    check("post_rst_err", 128'(dut_if.err_count), 128'(0));

    repeat (4) @(negedge clk);
    check("exp_q_drained", 128'(exp_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "time limit");
  end
endmodule
